// File: rtl/gate_truth_sequencer_pkg.sv
// Shared types and the reference truth table for the gate self-test sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NAND
    } op_e;

    function automatic logic expected(op_e op, logic a, logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Start/op request, GUT drive/sense and LED status signals of the gate sequencer.
interface gate_truth_sequencer_if;

    logic       start_i;
    logic [1:0] op_i;
    logic       a_o;
    logic       b_o;
    logic       c_i;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [4:0] led_o;

    modport master (
        output start_i, op_i, c_i,
        input  a_o, b_o, busy_o, done_o, pass_o, led_o
    );

    modport slave (
        input  start_i, op_i, c_i,
        output a_o, b_o, busy_o, done_o, pass_o, led_o
    );

endinterface

// File: rtl/gate_truth_sequencer_hold_counter.sv
// Per-combination hold timer: counts 0..tick_count_p-1, flags the terminal count.
module hold_counter #(
    parameter int tick_count_p = 12000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam int cnt_w = $clog2(tick_count_p);
    localparam logic [cnt_w-1:0] last_val = cnt_w'(tick_count_p - 1);

    logic [cnt_w-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + cnt_w'(1);
        end
    end

    assign last_o = (cnt == last_val);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a two-input gate through 00,01,10,11, checks each output against the
// selected operation and reports per-combination and overall pass on the LEDs.
//
//   state | meaning
//   IDLE  | after reset, GUT inputs 0, waiting for start rising edge
//   DRIVE | holding combination k for tick_count_p cycles, sampling at the end
//   DONE  | results valid, inputs held at 11, new start reruns
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int tick_count_p = 12000000
) (
    input logic                   clk_i,
    input logic                   reset_i,
    gate_truth_sequencer_if.slave bus
);

    state_e     state, state_next;
    op_e        op_q, op_next;
    logic [1:0] k, k_next;
    logic [3:0] result, result_next;
    logic       start_q;
    logic       start_rise;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_last;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    // History resets high so a start level held through reset is not an edge.
    assign start_rise = bus.start_i & ~start_q;

    hold_counter #(
        .tick_count_p(tick_count_p)
    ) u_hold (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(cnt_clear),
        .en_i   (cnt_en),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            op_q    <= OP_AND;
            k       <= 2'd0;
            result  <= 4'd0;
            start_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state   <= state_next;
            op_q    <= op_next;
            k       <= k_next;
            result  <= result_next;
            start_q <= bus.start_i;
            busy_q  <= (state_next == DRIVE);
            done_q  <= (state_next == DONE);
            pass_q  <= (state_next == DONE) && (&result_next);
        end
    end

    always_comb begin
        state_next  = state;
        op_next     = op_q;
        k_next      = k;
        result_next = result;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_next  = DRIVE;
                    op_next     = op_e'(bus.op_i);
                    k_next      = 2'd0;
                    result_next = 4'd0;
                    cnt_clear   = 1'b1;
                end
            end
            DRIVE: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    result_next[k] = (bus.c_i == expected(op_q, k[1], k[0]));
                    cnt_clear      = 1'b1;
                    if (k == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        k_next = k + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // k sits at 0 in IDLE and at 3 in DONE, so it drives the GUT directly.
    assign bus.a_o    = k[1];
    assign bus.b_o    = k[0];
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.pass_o = pass_q;
    assign bus.led_o  = {pass_q, result};

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Randomized self-checking bench for gate_truth_sequencer with a behavioural GUT.
module tb_gate_truth_sequencer;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   gut_mode = 0;

    always #5 clk = ~clk;

    gate_truth_sequencer_if bus ();

    gate_truth_sequencer #(
        .tick_count_p(T)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    // Truth tables as 4-bit vectors, bit k = output for (a,b) = (k[1],k[0]).
    // Op tables: AND, OR, XOR, NAND. GUT tables add stuck-at-0 and stuck-at-1.
    logic [3:0] op_tab[4]  = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    logic [3:0] gut_tab[6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0000, 4'b1111};

    always_comb begin
        logic [3:0] tab;
        tab = gut_tab[gut_mode];
        bus.c_i = tab[{bus.a_o, bus.b_o}];
    end

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%b exp=%b (busy,done,pass,a,b,led)", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sample();
        return {bus.busy_o, bus.done_o, bus.pass_o, bus.a_o, bus.b_o, bus.led_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sequence from a start edge, checking every cycle up to done.
    // abort_m > 0 asserts reset during cycle abort_m instead of finishing.
    task automatic run_seq(input int op, input int mode, input bit noise, input int abort_m);
        logic [3:0] flags;
        logic [3:0] mask;
        logic [9:0] exp;
        int         k;
        gut_mode    = mode;
        bus.op_i    = 2'(op);
        flags       = ~(gut_tab[mode] ^ op_tab[op]);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int m = 1; m <= 4 * T + 1; m++) begin
            if (m <= 4 * T) begin
                k    = (m - 1) / T;
                mask = 4'((1 << k) - 1);
                exp  = {1'b1, 1'b0, 1'b0, k[1], k[0], 1'b0, flags & mask};
            end else begin
                exp = {1'b0, 1'b1, &flags, 1'b1, 1'b1, &flags, flags};
            end
            chk("run_cycle", sample(), exp);
            if (m == abort_m) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("reset_mid_run", sample(), 10'd0);
                step();
                chk("idle_after_reset", sample(), 10'd0);
                return;
            end
            if (m <= 4 * T) begin
                if (noise && m < 4 * T) begin
                    bus.start_i = 1'($urandom_range(0, 1));
                    bus.op_i    = 2'($urandom_range(0, 3));
                end else begin
                    bus.start_i = 1'b0;
                end
                step();
            end
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = 2'd0;
        reset       = 1'b1;
        repeat (3) step();
        chk("reset_state", sample(), 10'd0);
        reset = 1'b0;
        step();
        chk("idle", sample(), 10'd0);

        // Correct AND gate, then XOR vs AND gate (only combination 0 agrees),
        // then NAND vs stuck-at-1; each started straight from DONE.
        run_seq(0, 0, 1'b0, 0);
        run_seq(2, 0, 1'b0, 0);
        run_seq(3, 5, 1'b0, 0);

        // Reset during combination 2, then a fresh full run.
        run_seq(0, 0, 1'b0, 2 * T + 1 + int'($urandom_range(0, T - 1)));
        run_seq(0, 0, 1'b0, 0);

        // Start held high through reset release must not launch a run.
        bus.start_i = 1'b1;
        reset       = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (4) begin
            step();
            chk("start_held_through_reset", sample(), 10'd0);
        end
        bus.start_i = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 0);
        end

        // Mid-run glitches on start/op must not perturb a correct run.
        run_seq(1, 1, 1'b1, 0);
        run_seq(3, 3, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
